// File: rtl/digital_tube_scan_driver_pkg.sv
// Shared constants, FSM state type and decode helpers for the digital tube scan driver.
// Optional leading-zero blanking is selected with DIGITAL_TUBE_LEADING_ZERO_BLANK_EN.
package digital_tube_pkg;

    localparam int DIGITS    = 6;
    localparam int BCD_W     = 24;
    localparam int BIN_W     = 20;
    localparam int MAX_VALUE = 999999;

    localparam logic [3:0] BCD_DASH  = 4'hA;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Active-high segment patterns, bit order g..a
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } conv_state_t;

    function automatic logic [7:0] seg_decode(input logic [3:0] code);
        logic [6:0] pattern;
        case (code)
            4'd0:     pattern = SEG_0;
            4'd1:     pattern = SEG_1;
            4'd2:     pattern = SEG_2;
            4'd3:     pattern = SEG_3;
            4'd4:     pattern = SEG_4;
            4'd5:     pattern = SEG_5;
            4'd6:     pattern = SEG_6;
            4'd7:     pattern = SEG_7;
            4'd8:     pattern = SEG_8;
            4'd9:     pattern = SEG_9;
            BCD_DASH: pattern = SEG_DASH;
            default:  pattern = SEG_BLANK;
        endcase
        return {1'b0, pattern};
    endfunction

    // Blanks the run of zero digits from the top down, never touching digit 0
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        logic             zero_run;
        res      = bcd;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (zero_run && (bcd[4*i +: 4] == 4'd0)) begin
                res[4*i +: 4] = BCD_BLANK;
            end else begin
                zero_run = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/digital_tube_scan_driver_if.sv
// Bundle between the register block (master) and the tube scan driver (slave).
interface digital_tube_scan_driver_if;
    import digital_tube_pkg::*;

    logic [BIN_W-1:0] display_num;
    logic             display_enable;
    logic [7:0]       seg;
    logic [5:0]       sel;
    logic             conv_busy;

    modport master (
        output display_num,
        output display_enable,
        input  seg,
        input  sel,
        input  conv_busy
    );

    modport slave (
        input  display_num,
        input  display_enable,
        output seg,
        output sel,
        output conv_busy
    );

endinterface

// File: rtl/digital_tube_scan_driver_bin2bcd.sv
// Sequential double-dabble converter with a shadow register that only changes atomically in DONE.
// DIGITAL_TUBE_LEADING_ZERO_BLANK_EN applies leading-zero blanking as the shadow is written.
module digital_tube_bin2bcd
    import digital_tube_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] i_num,
    output logic [BCD_W-1:0] o_bcd,
    output logic             o_busy
);

    conv_state_t              r_state;
    conv_state_t              w_next_state;
    logic [BIN_W-1:0]         r_num_cap;
    logic [BCD_W+BIN_W-1:0]   r_shift;
    logic [4:0]               r_bit_cnt;
    logic [BCD_W-1:0]         r_bcd_shadow;
    logic [BCD_W-1:0]         w_adjusted;
    logic [BCD_W-1:0]         w_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (i_num != r_num_cap) w_next_state = ST_LOAD;
            ST_LOAD:  w_next_state = ST_SHIFT;
            ST_SHIFT: if (r_bit_cnt == 5'd0) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_adjusted = r_shift[BIN_W +: BCD_W];
        for (int i = 0; i < DIGITS; i++) begin
            if (r_shift[BIN_W + 4*i +: 4] >= 4'd5) begin
                w_adjusted[4*i +: 4] = r_shift[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Overrange wins over blanking so a too-large value always reads as dashes
    always_comb begin
        if (32'(r_num_cap) > MAX_VALUE) begin
            w_result = {DIGITS{BCD_DASH}};
        end else begin
`ifdef DIGITAL_TUBE_LEADING_ZERO_BLANK_EN
            w_result = blank_leading(r_shift[BIN_W +: BCD_W]);
`else
            w_result = r_shift[BIN_W +: BCD_W];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_cap    <= '0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_bcd_shadow <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_num_cap <= i_num;
                    r_shift   <= {{BCD_W{1'b0}}, i_num};
                    r_bit_cnt <= 5'(BIN_W - 1);
                end
                ST_SHIFT: begin
                    r_shift <= {w_adjusted, r_shift[BIN_W-1:0]} << 1;
                    if (r_bit_cnt != 5'd0) begin
                        r_bit_cnt <= r_bit_cnt - 5'd1;
                    end
                end
                ST_DONE: begin
                    r_bcd_shadow <= w_result;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_bcd  = r_bcd_shadow;
    assign o_busy = (r_state != ST_IDLE);

endmodule

// File: rtl/digital_tube_scan_driver.sv
// Time-multiplexed 6-digit common-segment tube driver fed by a background BCD converter.
// Build with DIGITAL_TUBE_LEADING_ZERO_BLANK_EN to blank leading zeros.
module digital_tube_scan_driver
    import digital_tube_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
)
(
    input  logic                        clk,
    input  logic                        rst_n,
    digital_tube_scan_driver_if.slave   bus
);

    localparam int               DIV      = CLK_FREQ_HZ / SCAN_HZ;
    localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [7:0]       SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [5:0]       SEL_OFF  = (SEL_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

    logic [BCD_W-1:0] w_bcd;
    logic             w_busy;
    logic [CNT_W-1:0] r_div_cnt;
    logic [2:0]       r_dig_idx;
    logic [7:0]       r_seg;
    logic [5:0]       r_sel;
    logic [3:0]       w_nibble;
    logic [5:0]       w_sel_hot;
    logic [7:0]       w_seg_hot;

    digital_tube_bin2bcd u_bin2bcd (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_num  (bus.display_num),
        .o_bcd  (w_bcd),
        .o_busy (w_busy)
    );

    always_comb begin
        w_nibble  = BCD_BLANK;
        w_sel_hot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (32'(r_dig_idx) == i) begin
                w_nibble     = w_bcd[4*i +: 4];
                w_sel_hot[i] = 1'b1;
            end
        end
        w_seg_hot = seg_decode(w_nibble);
    end

    // Outputs are registered from the current index, so a shadow update lands one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_dig_idx <= '0;
            r_seg     <= SEG_OFF;
            r_sel     <= SEL_OFF;
        end else if (!bus.display_enable) begin
            r_div_cnt <= '0;
            r_dig_idx <= '0;
            r_seg     <= SEG_OFF;
            r_sel     <= SEL_OFF;
        end else begin
            r_sel <= (SEL_ACTIVE_LOW != 0) ? ~w_sel_hot : w_sel_hot;
            r_seg <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_hot : w_seg_hot;
            if (r_div_cnt == DIV_LAST) begin
                r_div_cnt <= '0;
                r_dig_idx <= (r_dig_idx == 3'(DIGITS - 1)) ? 3'd0 : r_dig_idx + 3'd1;
            end else begin
                r_div_cnt <= r_div_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.seg       = r_seg;
    assign bus.sel       = r_sel;
    assign bus.conv_busy = w_busy;

endmodule

// File: tb/tb_digital_tube_scan_driver.sv
// Self-checking bench: directed steps plus random values against a decimal-arithmetic display model.
module tb_digital_tube_scan_driver;

    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   v;

    digital_tube_scan_driver_if bus();

    digital_tube_scan_driver #(
        .CLK_FREQ_HZ    (1000),
        .SCAN_HZ        (100),
        .SEG_ACTIVE_LOW (1),
        .SEL_ACTIVE_LOW (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: what digit k should show, 0..9, 10 for dash, 15 for blank
    function automatic int expCode(input int num, input int k);
        int p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (num > 999999) return 10;
`ifdef DIGITAL_TUBE_LEADING_ZERO_BLANK_EN
        if (k >= 1 && (num / p) == 0) return 15;
`endif
        return (num / p) % 10;
    endfunction

    function automatic logic [7:0] expSegOf(input int code);
        case (code)
            0:       return 8'hC0;
            1:       return 8'hF9;
            2:       return 8'hA4;
            3:       return 8'hB0;
            4:       return 8'h99;
            5:       return 8'h92;
            6:       return 8'h82;
            7:       return 8'hF8;
            8:       return 8'h80;
            9:       return 8'h90;
            10:      return 8'hBF;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [23:0] expBcd(input int num);
        logic [23:0] r;
        r = '0;
        for (int k = 0; k < 6; k++) r[4*k +: 4] = 4'(expCode(num, k));
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [23:0] observed, input logic [23:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int num, input logic en);
        bus.display_num    = 20'(num);
        bus.display_enable = en;
    endtask

    task automatic checkBlankOutputs(input string tag);
        checkOutput({tag, "_sel"}, 24'(bus.sel), 24'h3F);
        checkOutput({tag, "_seg"}, 24'(bus.seg), 24'hFF);
    endtask

    // Converts with the display off, then scans all six digits for DIV cycles each
    task automatic checkScan(input int num);
        logic [5:0] expSel;
        int         k;
        applyStimulus(num, 1'b0);
        repeat (30) @(negedge clk);
        checkOutput("busy_settled", 24'(bus.conv_busy), 24'd0);
        checkOutput($sformatf("shadow_%0d", num), dut.w_bcd, expBcd(num));
        bus.display_enable = 1'b1;
        for (int c = 0; c < 6 * DIV; c++) begin
            @(negedge clk);
            k      = c / DIV;
            expSel = 6'h3F ^ (6'h01 << k);
            checkOutput($sformatf("sel_%0d_c%0d", num, c), 24'(bus.sel), 24'(expSel));
            checkOutput($sformatf("seg_%0d_c%0d", num, c), 24'(bus.seg), 24'(expSegOf(expCode(num, k))));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 1'b0);
        repeat (2) @(negedge clk);
        checkBlankOutputs("reset");
        checkOutput("reset_busy", 24'(bus.conv_busy), 24'd0);
        checkOutput("reset_shadow", dut.w_bcd, 24'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("no_conv_for_zero", 24'(bus.conv_busy), 24'd0);

        // Conversion latency: busy through LOAD/SHIFT/DONE, shadow valid right after DONE
        bus.display_num = 20'd999999;
        for (int k = 0; k <= 22; k++) begin
            @(negedge clk);
            checkOutput($sformatf("lat_busy_k%0d", k), 24'(bus.conv_busy), (k <= 21) ? 24'd1 : 24'd0);
            if (k == 21) checkOutput("lat_shadow_old", dut.w_bcd, 24'd0);
        end
        checkOutput("lat_shadow_new", dut.w_bcd, 24'h999999);

        checkScan(123456);
        checkScan(1048575);
        checkScan(42);
        checkScan(0);
        for (int i = 0; i < 4; i++) begin
            v = int'($urandom_range(999999, 0));
            checkScan(v);
        end

        // Change mid-conversion: the first result lands, then a second conversion follows
        applyStimulus(1000, 1'b0);
        for (int k = 0; k <= 23; k++) begin
            @(negedge clk);
            if (k == 5) bus.display_num = 20'd2000;
            if (k == 22) begin
                checkOutput("mid_first_result", dut.w_bcd, expBcd(1000));
                checkOutput("mid_idle_gap", 24'(bus.conv_busy), 24'd0);
            end
            if (k == 23) checkOutput("mid_restart", 24'(bus.conv_busy), 24'd1);
        end
        repeat (22) @(negedge clk);
        checkOutput("mid_final_result", dut.w_bcd, expBcd(2000));
        checkScan(2000);

        // Enable toggle: drop during digit 3, restart from digit 0
        bus.display_enable = 1'b0;
        @(negedge clk);
        bus.display_enable = 1'b1;
        repeat (35) @(negedge clk);
        checkOutput("tog_digit3_sel", 24'(bus.sel), 24'h37);
        bus.display_enable = 1'b0;
        @(negedge clk);
        checkBlankOutputs("tog_off");
        bus.display_enable = 1'b1;
        @(negedge clk);
        checkOutput("tog_restart_sel", 24'(bus.sel), 24'h3E);
        checkOutput("tog_restart_seg", 24'(bus.seg), 24'(expSegOf(expCode(2000, 0))));
        repeat (10) @(negedge clk);
        checkOutput("tog_digit1_sel", 24'(bus.sel), 24'h3D);

        // Asynchronous reset in the middle of a shift discards the partial result
        v = int'($urandom_range(999999, 1));
        if (v == 2000) v = 2001;
        bus.display_num = 20'(v);
        repeat (8) @(negedge clk);
        checkOutput("pre_rst_busy", 24'(bus.conv_busy), 24'd1);
        rst_n = 1'b0;
        #1;
        checkBlankOutputs("midrst");
        checkOutput("midrst_busy", 24'(bus.conv_busy), 24'd0);
        checkOutput("midrst_shadow", dut.w_bcd, 24'd0);
        @(negedge clk);
        rst_n = 1'b1;
        checkScan(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
